// File: rtl/ha_array_reducer.sv
// ha_array_reducer
//   Sequential back end of the unsigned 8x8 ha_array multiplier. Captures one
//   bundle of four (b, t) groups, accumulates the weighted groups PAR at a time
//   over 4/PAR cycles, then holds the saturated 16-bit product until consumed.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid / in_ready        bundle handshake
//   ha_array_g_b [6:0]         carry row of group g, bit i weight 2^(i+2+2g)
//   ha_array_g_t [8:0]         sum row of group g,   bit i weight 2^(i+2g)
//   out_valid / out_ready      result handshake
//   product [15:0]             saturated product
//   ovf                        unsaturated sum exceeded 16'hFFFF
module ha_array_reducer #(
  parameter int unsigned PAR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  ha_array_0_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [6:0]  ha_array_1_b,
  input  logic [8:0]  ha_array_1_t,
  input  logic [6:0]  ha_array_2_b,
  input  logic [8:0]  ha_array_2_t,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        ovf
);

  if (!(PAR == 1 || PAR == 2 || PAR == 4)) begin : g_bad_par
    $error("ha_array_reducer: PAR must be 1, 2 or 4");
  end

  localparam int unsigned NCYC = 4 / PAR;
  localparam logic [1:0]  LAST = 2'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state, state_next;
  logic [6:0]  b_q [4];
  logic [8:0]  t_q [4];
  logic [16:0] acc;
  logic [16:0] acc_next;
  logic [16:0] grp;
  logic [1:0]  gidx;
  logic [1:0]  cnt;
  logic        capture;
  logic        last;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign capture   = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign last      = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (capture) state_next = ACC;
      ACC:  if (last) state_next = DONE;
      DONE: if (out_ready) state_next = in_valid ? ACC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Partial sum of the PAR groups selected by cnt, each weighted by 4^g.
  always_comb begin
    acc_next = acc;
    grp      = '0;
    gidx     = '0;
    for (int unsigned k = 0; k < PAR; k++) begin
      gidx     = 2'(32'(cnt) * PAR + k);
      grp      = 17'(t_q[gidx]) + (17'(b_q[gidx]) << 2);
      acc_next = acc_next + (grp << {gidx, 1'b0});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        b_q[i] <= '0;
        t_q[i] <= '0;
      end
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (capture) begin
      b_q[0] <= ha_array_0_b;
      b_q[1] <= ha_array_1_b;
      b_q[2] <= ha_array_2_b;
      b_q[3] <= ha_array_3_b;
      t_q[0] <= ha_array_0_t;
      t_q[1] <= ha_array_1_t;
      t_q[2] <= ha_array_2_t;
      t_q[3] <= ha_array_3_t;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ACC) begin
      acc <= acc_next;
      cnt <= cnt + 2'd1;
      if (last) begin
        // Max sum is below 2^17, so bit 16 alone flags overflow.
        product <= acc_next[16] ? '1 : acc_next[15:0];
        ovf     <= acc_next[16];
      end
    end
  end

endmodule
